// File: rtl/reg_status_table.sv
`default_nettype none
// ============================================================================
// Module      : reg_status_table
// Description : Register-status table mapping each architectural register to
//               the ROB tag of its newest in-flight producer. Optional
//               same-edge commit bypass on lookups via COMMIT_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_status_table #(
    parameter int NUM_REGS        = 32,
    parameter int TAG_W           = 4,
    parameter int ZERO_REG_EN_IDX = 0,
    localparam int RIDX_W         = $clog2(NUM_REGS),
    localparam int CNT_W          = $clog2(NUM_REGS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lookup_req,
    input  logic [RIDX_W-1:0] src1,
    input  logic [RIDX_W-1:0] src2,
    output logic              lookup_ack,
    output logic              q1_busy,
    output logic [TAG_W-1:0]  q1_tag,
    output logic              q2_busy,
    output logic [TAG_W-1:0]  q2_tag,
    input  logic              rename_valid,
    input  logic [RIDX_W-1:0] rename_reg,
    input  logic [TAG_W-1:0]  rename_tag,
    input  logic              commit_valid,
    input  logic [RIDX_W-1:0] commit_reg,
    input  logic [TAG_W-1:0]  commit_tag,
    input  logic              flush,
    input  logic [RIDX_W-1:0] probe_reg,
    output logic              probe_busy,
    output logic [TAG_W-1:0]  probe_tag,
    output logic [CNT_W-1:0]  busy_count
);

    logic [NUM_REGS-1:0] r_busy;
    logic [TAG_W-1:0]    r_tag [NUM_REGS];
    logic [CNT_W-1:0]    r_count;

    logic                w_ren_ok;
    logic                w_ren_new;
    logic                w_cmt_hit;
    logic                w_cmt_clr;
    logic                w_s1_busy;
    logic [TAG_W-1:0]    w_s1_tag;
    logic                w_s2_busy;
    logic [TAG_W-1:0]    w_s2_tag;
    logic                w_pr_busy;
    logic [TAG_W-1:0]    w_pr_tag;

    // The hardwired register and out-of-range indices never hold state.
    function automatic logic idx_ok(input logic [RIDX_W-1:0] idx);
        return (int'(idx) < NUM_REGS) && (int'(idx) != ZERO_REG_EN_IDX);
    endfunction

    function automatic logic entry_busy(input logic [RIDX_W-1:0] idx,
                                        input logic [NUM_REGS-1:0] busy_vec);
        return idx_ok(idx) && busy_vec[idx];
    endfunction

    always_comb begin
        w_ren_ok  = rename_valid && !flush && idx_ok(rename_reg);
        w_ren_new = w_ren_ok && !r_busy[rename_reg];
        w_cmt_hit = commit_valid && !flush && idx_ok(commit_reg) &&
                    r_busy[commit_reg] && (r_tag[commit_reg] == commit_tag);
        // A same-edge rename of the committed register keeps ownership.
        w_cmt_clr = w_cmt_hit && !(w_ren_ok && (rename_reg == commit_reg));
    end

    always_comb begin
        w_s1_busy = entry_busy(src1, r_busy);
        w_s1_tag  = w_s1_busy ? r_tag[src1] : '0;
        w_s2_busy = entry_busy(src2, r_busy);
        w_s2_tag  = w_s2_busy ? r_tag[src2] : '0;
`ifdef COMMIT_BYPASS_EN
        // Consumer would miss the broadcast; point it at the committed value.
        if (w_cmt_clr && (src1 == commit_reg)) begin
            w_s1_busy = 1'b0;
            w_s1_tag  = '0;
        end
        if (w_cmt_clr && (src2 == commit_reg)) begin
            w_s2_busy = 1'b0;
            w_s2_tag  = '0;
        end
`endif
        w_pr_busy = entry_busy(probe_reg, r_busy);
        w_pr_tag  = w_pr_busy ? r_tag[probe_reg] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy     <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_tag[i] <= '0;
            end
            r_count    <= '0;
            lookup_ack <= 1'b0;
            q1_busy    <= 1'b0;
            q1_tag     <= '0;
            q2_busy    <= 1'b0;
            q2_tag     <= '0;
            probe_busy <= 1'b0;
            probe_tag  <= '0;
        end else begin
            if (flush) begin
                r_busy  <= '0;
                r_count <= '0;
            end else begin
                if (w_cmt_clr) begin
                    r_busy[commit_reg] <= 1'b0;
                end
                if (w_ren_ok) begin
                    r_busy[rename_reg] <= 1'b1;
                    r_tag[rename_reg]  <= rename_tag;
                end
                r_count <= r_count + CNT_W'(w_ren_new) - CNT_W'(w_cmt_clr);
            end

            lookup_ack <= lookup_req;
            if (lookup_req) begin
                q1_busy <= w_s1_busy;
                q1_tag  <= w_s1_tag;
                q2_busy <= w_s2_busy;
                q2_tag  <= w_s2_tag;
            end

            probe_busy <= w_pr_busy;
            probe_tag  <= w_pr_tag;
        end
    end

    assign busy_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_reg_status_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_status_table
// Description : Scoreboard bench for reg_status_table against an array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_status_table;

    localparam int NR = 32;
    localparam int TW = 4;
    localparam int RW = 5;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          lookup_req;
    logic [RW-1:0] src1, src2;
    logic          lookup_ack;
    logic          q1_busy, q2_busy;
    logic [TW-1:0] q1_tag, q2_tag;
    logic          rename_valid;
    logic [RW-1:0] rename_reg;
    logic [TW-1:0] rename_tag;
    logic          commit_valid;
    logic [RW-1:0] commit_reg;
    logic [TW-1:0] commit_tag;
    logic          flush;
    logic [RW-1:0] probe_reg;
    logic          probe_busy;
    logic [TW-1:0] probe_tag;
    logic [CW-1:0] busy_count;

    reg_status_table #(.NUM_REGS(NR), .TAG_W(TW), .ZERO_REG_EN_IDX(0)) dut (
        .clk(clk), .rst(rst),
        .lookup_req(lookup_req), .src1(src1), .src2(src2),
        .lookup_ack(lookup_ack),
        .q1_busy(q1_busy), .q1_tag(q1_tag), .q2_busy(q2_busy), .q2_tag(q2_tag),
        .rename_valid(rename_valid), .rename_reg(rename_reg), .rename_tag(rename_tag),
        .commit_valid(commit_valid), .commit_reg(commit_reg), .commit_tag(commit_tag),
        .flush(flush),
        .probe_reg(probe_reg), .probe_busy(probe_busy), .probe_tag(probe_tag),
        .busy_count(busy_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            stamp;
        logic          b1;
        logic [TW-1:0] t1;
        logic          b2;
        logic [TW-1:0] t2;
    } lk_t;

    typedef struct {
        int            stamp;
        logic          rst;
        logic          pb;
        logic [TW-1:0] pt;
        logic [CW-1:0] cnt;
    } st_t;

    lk_t lq[$];
    st_t sq[$];

    // Reference model: one busy flag and tag per architectural register.
    logic          mb [NR];
    logic [TW-1:0] mt [NR];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic          hb1 = 1'b0, hb2 = 1'b0;
    logic [TW-1:0] ht1 = '0, ht2 = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit valid_idx(input int idx);
        return (idx != 0) && (idx < NR);
    endfunction

    function automatic void mlook(input int idx, output logic b, output logic [TW-1:0] t);
        if (valid_idx(idx) && mb[idx]) begin
            b = 1'b1;
            t = mt[idx];
        end else begin
            b = 1'b0;
            t = '0;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input bit r, input bit lr, input int s1, input int s2,
                        input bit rv, input int rr, input int rt,
                        input bit cv, input int cr, input int ct,
                        input bit fl, input int pr);
        st_t  se;
        lk_t  le;
        bit   cclr;
        int   n;
        @(negedge clk);
        rst          = r;
        lookup_req   = lr;
        src1         = RW'(s1);
        src2         = RW'(s2);
        rename_valid = rv;
        rename_reg   = RW'(rr);
        rename_tag   = TW'(rt);
        commit_valid = cv;
        commit_reg   = RW'(cr);
        commit_tag   = TW'(ct);
        flush        = fl;
        probe_reg    = RW'(pr);

        se.stamp = cyc;
        se.rst   = r;
        if (r) begin
            se.pb = 1'b0;
            se.pt = '0;
        end else begin
            mlook(pr, se.pb, se.pt);
        end

        cclr = !r && !fl && cv && valid_idx(cr) && mb[cr] && (mt[cr] == TW'(ct)) &&
               !(rv && valid_idx(rr) && rr == cr);

        if (lr && !r) begin
            le.stamp = cyc;
            mlook(s1, le.b1, le.t1);
            mlook(s2, le.b2, le.t2);
`ifdef COMMIT_BYPASS_EN
            if (cclr && s1 == cr) begin le.b1 = 1'b0; le.t1 = '0; end
            if (cclr && s2 == cr) begin le.b2 = 1'b0; le.t2 = '0; end
`endif
            lq.push_back(le);
        end

        if (r) begin
            for (int i = 0; i < NR; i++) begin mb[i] = 1'b0; mt[i] = '0; end
        end else if (fl) begin
            for (int i = 0; i < NR; i++) mb[i] = 1'b0;
        end else begin
            if (cclr) mb[cr] = 1'b0;
            if (rv && valid_idx(rr)) begin mb[rr] = 1'b1; mt[rr] = TW'(rt); end
        end

        n = 0;
        for (int i = 0; i < NR; i++) if (mb[i]) n++;
        se.cnt = CW'(n);
        sq.push_back(se);
    endtask

    task automatic idle(input int pr);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, pr);
    endtask

    // Monitor: pops expectations as the DUT presents results.
    always @(negedge clk) begin
        st_t se;
        lk_t le;
        bit  exp_ack;
        if (cyc >= 1) begin
            if (sq.size() > 0 && sq[0].stamp == cyc - 1) begin
                se = sq.pop_front();
                chk("probe_busy", 32'(probe_busy), 32'(se.pb));
                chk("probe_tag", 32'(probe_tag), 32'(se.pt));
                chk("busy_count", 32'(busy_count), 32'(se.cnt));
                if (se.rst) begin
                    hb1 = 1'b0; ht1 = '0; hb2 = 1'b0; ht2 = '0;
                end
            end
            while (lq.size() > 0 && lq[0].stamp < cyc - 1) begin
                le = lq.pop_front();
                bad++;
                total++;
                $display("FAIL lookup_lost: got no ack expected ack for request at cycle %0d", le.stamp);
            end
            exp_ack = (lq.size() > 0) && (lq[0].stamp == cyc - 1);
            chk("lookup_ack", 32'(lookup_ack), 32'(exp_ack));
            if (exp_ack) begin
                le = lq.pop_front();
                hb1 = le.b1; ht1 = le.t1; hb2 = le.b2; ht2 = le.t2;
            end
            chk("q1_busy", 32'(q1_busy), 32'(hb1));
            chk("q1_tag", 32'(q1_tag), 32'(ht1));
            chk("q2_busy", 32'(q2_busy), 32'(hb2));
            chk("q2_tag", 32'(q2_tag), 32'(ht2));
        end
    end

    function automatic int rnd_idx();
        if ($urandom_range(0, 3) != 0) return int'($urandom_range(0, 7));
        return int'($urandom_range(0, NR - 1));
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; lookup_req = 1'b0; src1 = '0; src2 = '0;
        rename_valid = 1'b0; rename_reg = '0; rename_tag = '0;
        commit_valid = 1'b0; commit_reg = '0; commit_tag = '0;
        flush = 1'b0; probe_reg = '0;
        for (int i = 0; i < NR; i++) begin mb[i] = 1'b0; mt[i] = '0; end

        repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < NR; i++) idle(i);

        step(0, 0, 0, 0, 1, 5, 3, 0, 0, 0, 0, 5);
        step(0, 1, 5, 6, 0, 0, 0, 0, 0, 0, 0, 5);
        idle(5);

        step(0, 0, 0, 0, 1, 5, 7, 0, 0, 0, 0, 5);
        step(0, 0, 0, 0, 0, 0, 0, 1, 5, 3, 0, 5);
        step(0, 0, 0, 0, 0, 0, 0, 1, 5, 7, 0, 5);
        idle(5);

        step(0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 31, 4, 0, 0, 0, 0, 0);
        idle(31);
        idle(0);

        step(0, 1, 9, 31, 1, 9, 5, 0, 0, 0, 0, 9);
        idle(9);
        step(0, 0, 0, 0, 1, 2, 1, 0, 0, 0, 1, 2);
        idle(2);

        step(0, 0, 0, 0, 1, 4, 6, 0, 0, 0, 0, 4);
        step(0, 1, 4, 0, 0, 0, 0, 1, 4, 6, 0, 4);
        step(0, 1, 4, 4, 1, 4, 9, 0, 0, 0, 0, 4);
        step(1, 1, 4, 4, 0, 0, 0, 0, 0, 0, 0, 4);
        idle(4);

        for (int n = 0; n < 2000; n++) begin
            automatic bit r  = ($urandom_range(0, 199) == 0);
            automatic bit lr = $urandom_range(0, 1) == 1;
            automatic bit rv = $urandom_range(0, 9) < 4;
            automatic bit cv = $urandom_range(0, 9) < 4;
            automatic bit fl = ($urandom_range(0, 39) == 0);
            automatic int cr = rnd_idx();
            automatic int ct = ($urandom_range(0, 1) == 1) ? int'(mt[cr]) : int'($urandom_range(0, 15));
            step(r, lr, rnd_idx(), rnd_idx(), rv, rnd_idx(), int'($urandom_range(0, 15)),
                 cv, cr, ct, fl, rnd_idx());
        end

        repeat (3) idle(0);
        chk("drain_lookups", 32'(lq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
